mem_arbiter: RTL and testbench
==============================

MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 Parameter TIMEOUT, default 1024: cycles allowed in ACCESS before abort.
REQ-002 Parameter ABORT_DATA, default 32'h00000000: read data returned on abort.
REQ-003 mclk  in  1  sole clock, all logic on rising edge.
REQ-004 reset  in  1  synchronous, active-high reset.
REQ-005 m0_rw_req, m1_rw_req  in  1 each  requester access request, held until own rec seen.
REQ-006 m0_rw, m1_rw  in  1 each  0=read, 1=write.
REQ-007 m0_address, m1_address  in  32 each  byte address.
REQ-008 m0_write_data, m1_write_data  in  32 each  store data.
REQ-009 m0_size, m1_size  in  2 each  0=byte, 1=half, 2=word.
REQ-010 m0_read_data, m1_read_data  out  32 each  registered load data, valid while own rec=1.
REQ-011 m0_rec, m1_rec  out  1 each  access-complete strobe to requester.
REQ-012 mem_address out 32, mem_rw out 1, mem_write_data out 32, mem_size out 2, mem_rw_req out 1: registered port to memory controller.
REQ-013 mem_read_data  in  32; mem_rec  in  1  controller data-valid/ack.
REQ-014 grant  out  1  index of current/last granted requester.
REQ-015 busy  out  1  high in any state other than IDLE.
REQ-016 timeout_err  out  1  sticky abort flag.

Function
REQ-017 State machine SHALL have three states: IDLE, ACCESS, RELEASE.
REQ-018 IDLE: if any mX_rw_req=1 and both mX_rec=0, select winner, latch its rw/address/write_data/size into mem_* registers, set mem_rw_req=1, go ACCESS; mem_rw_req high exactly 1 cycle after request sampled.
REQ-019 Arbitration: single requester wins; both requesting -> requester not equal to last_grant wins (round-robin); last_grant updates on entering ACCESS.
REQ-020 Loser's request SHALL stay pending, untouched, and be served next IDLE.
REQ-021 ACCESS: mem_* outputs stable; on mem_rec=1 register mem_read_data into winner's mX_read_data, set winner mX_rec=1, clear mem_rw_req, go RELEASE (rec visible 1 cycle after mem_rec).
REQ-022 Writes SHALL follow identical handshake; mX_read_data still updated from mem_read_data.
REQ-023 ACCESS cycle counter: counts from 0 on entry; if it reaches TIMEOUT-1 with mem_rec=0, next cycle clears mem_rw_req, loads ABORT_DATA into winner read_data, sets winner rec=1, sets timeout_err=1, goes RELEASE.
REQ-024 RELEASE: hold winner mX_rec=1 and read_data until winner mX_rw_req=0 AND mem_rec=0 in same cycle; then clear mX_rec, go IDLE.
REQ-025 No new memory request SHALL issue while mem_rec=1 (ensures controller handshake fully closed).
REQ-026 Non-granted requester's rec SHALL never assert; at most one mX_rec high at any time.
REQ-027 Minimum turnaround: one IDLE cycle between RELEASE exit and next mem_rw_req rise.
REQ-028 Requester dropping mX_rw_req during ACCESS (protocol violation) SHALL be ignored; access completes normally.

Reset
REQ-029 reset=1 SHALL, next edge, force IDLE, mem_rw_req=0, mem_rw=0, mem_address=0, mem_write_data=0, mem_size=0, m0_rec=m1_rec=0, m0/m1_read_data=0, timeout_err=0, busy=0, counter=0, last_grant=grant=1 (m0 wins first tie).
REQ-030 reset asserted mid-ACCESS or RELEASE SHALL abort access without completing rec; any stale mem_rec after reset ignored until a new request issues.

Verification
REQ-031 m0 read addr 0x18 alone, controller returns 0x000000C0 after 3 cycles -> mem_rw_req rises 1 cycle after m0_rw_req, m0_rec=1 with m0_read_data=0x000000C0 1 cycle after mem_rec, m1_rec stays 0.
REQ-032 m0 and m1 request same cycle after reset -> m0 served first (grant=0), m1 served next, grant=1; repeat both -> m0 again.
REQ-033 m1 word write addr 0x1FFC data 0x12345678 size 2 -> mem_address=0x1FFC, mem_write_data=0x12345678, mem_rw=1, mem_size=2 stable from request to mem_rec.
REQ-034 Controller never asserts mem_rec, TIMEOUT=16 -> mem_rw_req drops 16 cycles after rising, m0_rec=1, m0_read_data=0, timeout_err=1 until reset.
REQ-035 Requester holds m0_rw_req 4 cycles after m0_rec -> m0_rec held 4 cycles, no second access issued, IDLE reached 1 cycle after release.
REQ-036 reset pulsed during ACCESS -> all outputs at reset values next cycle, subsequent request completes normally.

Source files
------------

// File: rtl/mem_arbiter_if.sv
// mem_arbiter_if -- bundle of every signal between the two-requester memory
// arbiter, its requesters (m0, m1) and the downstream memory controller.
//
// Signals:
//   mX_rw_req     requester access request (held until own rec seen)
//   mX_rw         0 = read, 1 = write
//   mX_address    byte address
//   mX_write_data store data
//   mX_size       0 = byte, 1 = half, 2 = word
//   mX_read_data  registered load data, valid while mX_rec = 1
//   mX_rec        access-complete strobe to requester
//   mem_*         registered request port to the memory controller
//   mem_read_data / mem_rec  controller data / acknowledge
//   grant, busy, timeout_err  arbiter status
//
// Modports:
//   slave  -- the arbiter's view
//   master -- the view of whatever drives the requesters and the controller
interface mem_arbiter_if;
  logic        m0_rw_req,     m1_rw_req;
  logic        m0_rw,         m1_rw;
  logic [31:0] m0_address,    m1_address;
  logic [31:0] m0_write_data, m1_write_data;
  logic [1:0]  m0_size,       m1_size;
  logic [31:0] m0_read_data,  m1_read_data;
  logic        m0_rec,        m1_rec;

  logic [31:0] mem_address;
  logic        mem_rw;
  logic [31:0] mem_write_data;
  logic [1:0]  mem_size;
  logic        mem_rw_req;
  logic [31:0] mem_read_data;
  logic        mem_rec;

  logic        grant;
  logic        busy;
  logic        timeout_err;

  modport slave (
    input  m0_rw_req, m1_rw_req, m0_rw, m1_rw, m0_address, m1_address,
           m0_write_data, m1_write_data, m0_size, m1_size,
           mem_read_data, mem_rec,
    output m0_read_data, m1_read_data, m0_rec, m1_rec,
           mem_address, mem_rw, mem_write_data, mem_size, mem_rw_req,
           grant, busy, timeout_err
  );

  modport master (
    output m0_rw_req, m1_rw_req, m0_rw, m1_rw, m0_address, m1_address,
           m0_write_data, m1_write_data, m0_size, m1_size,
           mem_read_data, mem_rec,
    input  m0_read_data, m1_read_data, m0_rec, m1_rec,
           mem_address, mem_rw, mem_write_data, mem_size, mem_rw_req,
           grant, busy, timeout_err
  );
endinterface

// File: rtl/mem_arbiter.sv
// mem_arbiter -- round-robin arbiter sharing one memory controller port
// between two requesters (m0, m1). An IDLE/ACCESS/RELEASE state machine
// latches the winner's request into registered mem_* outputs, waits for the
// controller acknowledge (or aborts after TIMEOUT cycles), returns the load
// data with a rec strobe, and holds rec until the winner drops its request.
//
// Parameters:
//   TIMEOUT     cycles allowed in ACCESS before the access is aborted
//   ABORT_DATA  read data returned to the requester on abort
// Ports:
//   mclk   sole clock, rising edge
//   reset  synchronous active-high reset
//   bus    mem_arbiter_if.slave (requesters, controller port, status)
module mem_arbiter #(
  parameter int          TIMEOUT    = 1024,
  parameter logic [31:0] ABORT_DATA = 32'h0000_0000
) (
  input  logic          mclk,
  input  logic          reset,
  mem_arbiter_if.slave  bus
);

  localparam int CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

  typedef enum logic [1:0] {IDLE, ACCESS, RELEASE} state_t;

  state_t             state, state_nxt;
  logic [CNT_W-1:0]   cnt;
  logic               last_grant;

  logic               issue, complete, abort, release_done;
  logic               pick;
  logic               win_req;
  logic [31:0]        ret_data;

  // Load data handed back to the winner: controller data or the abort value.
  assign ret_data = complete ? bus.mem_read_data : ABORT_DATA;

  assign bus.grant = last_grant;
  assign bus.busy  = (state != IDLE);

  // Next-state and per-cycle strobes
  always_comb begin
    state_nxt    = state;
    issue        = 1'b0;
    complete     = 1'b0;
    abort        = 1'b0;
    release_done = 1'b0;
    pick         = last_grant;
    win_req      = last_grant ? bus.m1_rw_req : bus.m0_rw_req;

    case (state)
      IDLE: begin
        // On a tie the requester that was not served last wins.
        if (bus.m0_rw_req && bus.m1_rw_req) pick = ~last_grant;
        else                                pick = bus.m1_rw_req;
        // A still-high mem_rec means the previous controller handshake has
        // not closed (or is stale from before a reset): do not issue.
        if ((bus.m0_rw_req || bus.m1_rw_req) && !bus.m0_rec && !bus.m1_rec
            && !bus.mem_rec) begin
          issue     = 1'b1;
          state_nxt = ACCESS;
        end
      end
      ACCESS: begin
        if (bus.mem_rec) begin
          complete  = 1'b1;
          state_nxt = RELEASE;
        end else if (cnt == CNT_W'(TIMEOUT - 1)) begin
          abort     = 1'b1;
          state_nxt = RELEASE;
        end
      end
      RELEASE: begin
        if (!win_req && !bus.mem_rec) begin
          release_done = 1'b1;
          state_nxt    = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // State, request port, and return-path registers
  always_ff @(posedge mclk) begin
    if (reset) begin
      state              <= IDLE;
      cnt                <= '0;
      last_grant         <= 1'b1;
      bus.mem_rw_req     <= 1'b0;
      bus.mem_rw         <= 1'b0;
      bus.mem_address    <= '0;
      bus.mem_write_data <= '0;
      bus.mem_size       <= '0;
      bus.m0_rec         <= 1'b0;
      bus.m1_rec         <= 1'b0;
      bus.m0_read_data   <= '0;
      bus.m1_read_data   <= '0;
      bus.timeout_err    <= 1'b0;
    end else begin
      state <= state_nxt;

      if (issue) begin
        last_grant         <= pick;
        cnt                <= '0;
        bus.mem_rw_req     <= 1'b1;
        bus.mem_rw         <= pick ? bus.m1_rw         : bus.m0_rw;
        bus.mem_address    <= pick ? bus.m1_address    : bus.m0_address;
        bus.mem_write_data <= pick ? bus.m1_write_data : bus.m0_write_data;
        bus.mem_size       <= pick ? bus.m1_size       : bus.m0_size;
      end

      if (state == ACCESS && !complete && !abort) cnt <= cnt + CNT_W'(1);

      // last_grant already names the winner while in ACCESS.
      if (complete || abort) begin
        bus.mem_rw_req <= 1'b0;
        if (last_grant) begin
          bus.m1_read_data <= ret_data;
          bus.m1_rec       <= 1'b1;
        end else begin
          bus.m0_read_data <= ret_data;
          bus.m0_rec       <= 1'b1;
        end
      end

      if (abort) bus.timeout_err <= 1'b1;

      if (release_done) begin
        bus.m0_rec <= 1'b0;
        bus.m1_rec <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter -- self-checking bench for mem_arbiter (TIMEOUT = 16).
// Transactions come from a vector table; each is pushed to an expectation
// queue when driven and popped when the DUT raises mem_rw_req.
module tb_mem_arbiter;

  logic mclk = 1'b0;
  logic reset;
  always #5 mclk = ~mclk;

  mem_arbiter_if bus();

  mem_arbiter #(.TIMEOUT(16), .ABORT_DATA(32'h0000_0000)) dut (
    .mclk  (mclk),
    .reset (reset),
    .bus   (bus)
  );

  typedef struct {
    logic        m;
    logic        rw;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [1:0]  size;
    logic [31:0] rdata;
    int          lat;
    int          hold;
  } vec_t;

  vec_t exp_q[$];
  int   n_chk  = 0;
  int   n_fail = 0;

  task automatic tick;
    @(posedge mclk);
    #1;
  endtask

  task automatic chk(input string name, input logic [71:0] act, input logic [71:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic drive_req(input vec_t v);
    if (!v.m) begin
      bus.m0_rw_req = 1'b1; bus.m0_rw = v.rw; bus.m0_address = v.addr;
      bus.m0_write_data = v.wdata; bus.m0_size = v.size;
    end else begin
      bus.m1_rw_req = 1'b1; bus.m1_rw = v.rw; bus.m1_address = v.addr;
      bus.m1_write_data = v.wdata; bus.m1_size = v.size;
    end
    exp_q.push_back(v);
  endtask

  task automatic check_reset_state(input string tag);
    chk({tag, "_mem_rw_req"}, bus.mem_rw_req, 1'b0);
    chk({tag, "_mem_port"}, {bus.mem_rw, bus.mem_address, bus.mem_write_data, bus.mem_size}, '0);
    chk({tag, "_recs"}, {bus.m0_rec, bus.m1_rec}, 2'b00);
    chk({tag, "_read_data"}, {bus.m0_read_data, bus.m1_read_data}, '0);
    chk({tag, "_timeout_err"}, bus.timeout_err, 1'b0);
    chk({tag, "_busy"}, bus.busy, 1'b0);
    chk({tag, "_grant"}, bus.grant, 1'b1);
  endtask

  // Wait for the next issued access, check it against the queue head, run
  // the controller side, and close the handshake from the winner's side.
  task automatic serve(output int waited);
    vec_t e;
    int   w;
    w = 0;
    while (!bus.mem_rw_req && w < 64) begin
      tick();
      w++;
    end
    waited = w;
    if (!bus.mem_rw_req || exp_q.size() == 0) begin
      n_chk++;
      n_fail++;
      $display("FAIL serve_issue: mem_rw_req=%0b queued=%0d after %0d cycles",
               bus.mem_rw_req, exp_q.size(), w);
      return;
    end
    e = exp_q.pop_front();
    chk("issue_port", {bus.mem_rw, bus.mem_address, bus.mem_write_data, bus.mem_size},
        {e.rw, e.addr, e.wdata, e.size});
    chk("issue_grant", bus.grant, e.m);
    chk("issue_busy", bus.busy, 1'b1);
    for (int i = 0; i < e.lat; i++) begin
      tick();
      chk("access_stable",
          {bus.mem_rw_req, bus.mem_rw, bus.mem_address, bus.mem_write_data, bus.mem_size},
          {1'b1, e.rw, e.addr, e.wdata, e.size});
    end
    bus.mem_read_data = e.rdata;
    bus.mem_rec = 1'b1;
    tick();
    bus.mem_rec = 1'b0;
    bus.mem_read_data = $urandom;
    chk("rec_winner", e.m ? {bus.m1_rec, bus.m0_rec} : {bus.m0_rec, bus.m1_rec}, 2'b10);
    chk("rec_data", e.m ? bus.m1_read_data : bus.m0_read_data, e.rdata);
    chk("rec_mem_req_low", bus.mem_rw_req, 1'b0);
    for (int i = 0; i < e.hold; i++) begin
      tick();
      chk("rec_held", {e.m ? bus.m1_rec : bus.m0_rec, bus.mem_rw_req, bus.busy}, 3'b101);
    end
    if (!e.m) bus.m0_rw_req = 1'b0;
    else      bus.m1_rw_req = 1'b0;
    tick();
    chk("release_idle", {bus.m0_rec, bus.m1_rec, bus.busy}, 3'b000);
  endtask

  vec_t vecs[5];
  vec_t tie0, tie1, v;
  int   w, cyc;

  initial begin
    vecs[0] = '{m:1'b0, rw:1'b0, addr:32'h18,       wdata:32'h0,        size:2'd2, rdata:32'h0000_00C0, lat:3, hold:0};
    vecs[1] = '{m:1'b1, rw:1'b1, addr:32'h1FFC,     wdata:32'h1234_5678, size:2'd2, rdata:32'hDEAD_BEEF, lat:2, hold:1};
    vecs[2] = '{m:1'b0, rw:1'b0, addr:32'h3,        wdata:32'h0,        size:2'd0, rdata:32'h0000_00A5, lat:0, hold:4};
    vecs[3] = '{m:1'b1, rw:1'b0, addr:32'h102,      wdata:32'h0,        size:2'd1, rdata:32'hFFFF_8001, lat:5, hold:2};
    vecs[4] = '{m:1'b0, rw:1'b1, addr:32'hFFFF_FFFC, wdata:32'hCAFE_F00D, size:2'd2, rdata:32'h5A5A_5A5A, lat:1, hold:0};
    tie0    = '{m:1'b0, rw:1'b0, addr:32'h40,       wdata:32'h0,        size:2'd2, rdata:32'h1111_0000, lat:1, hold:0};
    tie1    = '{m:1'b1, rw:1'b1, addr:32'h80,       wdata:32'h2222_3333, size:2'd2, rdata:32'h4444_5555, lat:2, hold:0};

    bus.m0_rw_req = 0; bus.m1_rw_req = 0; bus.m0_rw = 0; bus.m1_rw = 0;
    bus.m0_address = 0; bus.m1_address = 0; bus.m0_write_data = 0; bus.m1_write_data = 0;
    bus.m0_size = 0; bus.m1_size = 0; bus.mem_read_data = 0; bus.mem_rec = 0;
    reset = 1'b1;
    tick();
    tick();
    reset = 1'b0;
    check_reset_state("reset");

    // Simultaneous requests twice: m0 first each round after m1 was last.
    for (int r = 0; r < 2; r++) begin
      drive_req(tie0);
      drive_req(tie1);
      serve(w);
      chk("tie_first_wait", w, 1);
      chk("tie_m1_pending", {bus.m1_rec, bus.m1_rw_req}, 2'b01);
      serve(w);
      chk("tie_second_wait", w, 1);
    end

    // Vector table: single requesters, various sizes / latencies / holds.
    for (int i = 0; i < 5; i++) begin
      drive_req(vecs[i]);
      serve(w);
      chk("req_to_mem_req_latency", w, 1);
    end

    // Requester drops its request mid-ACCESS: access still completes.
    bus.m1_rw_req = 1'b1; bus.m1_rw = 1'b0; bus.m1_address = 32'h200; bus.m1_size = 2'd2;
    tick();
    chk("drop_issue", bus.mem_rw_req, 1'b1);
    bus.m1_rw_req = 1'b0;
    tick();
    tick();
    chk("drop_still_access", {bus.mem_rw_req, bus.busy, bus.m1_rec}, 3'b110);
    bus.mem_read_data = 32'h0000_0777;
    bus.mem_rec = 1'b1;
    tick();
    bus.mem_rec = 1'b0;
    chk("drop_rec", {bus.m1_rec, bus.m0_rec, bus.m1_read_data}, {2'b10, 32'h0000_0777});
    tick();
    chk("drop_idle", {bus.m1_rec, bus.busy}, 2'b00);

    // A lingering mem_rec blocks the next issue until it clears.
    bus.mem_rec = 1'b1;
    v = '{m:1'b0, rw:1'b0, addr:32'h300, wdata:32'h0, size:2'd2, rdata:32'h0BAD_CAFE, lat:2, hold:0};
    drive_req(v);
    tick();
    tick();
    chk("stale_rec_blocks", {bus.mem_rw_req, bus.busy}, 2'b00);
    bus.mem_rec = 1'b0;
    serve(w);
    chk("stale_rec_then_issue", w, 1);

    // Controller never answers: abort after 16 cycles with ABORT_DATA.
    bus.m0_rw_req = 1'b1; bus.m0_rw = 1'b0; bus.m0_address = 32'h400; bus.m0_size = 2'd2;
    tick();
    chk("to_issue", bus.mem_rw_req, 1'b1);
    cyc = 0;
    while (bus.mem_rw_req && cyc < 40) begin
      tick();
      cyc++;
    end
    chk("to_cycles", cyc, 16);
    chk("to_rec", {bus.m0_rec, bus.m1_rec, bus.timeout_err}, 3'b101);
    chk("to_abort_data", bus.m0_read_data, 32'h0000_0000);
    bus.m0_rw_req = 1'b0;
    tick();
    chk("to_sticky", {bus.timeout_err, bus.m0_rec, bus.busy}, 3'b100);
    v = '{m:1'b1, rw:1'b0, addr:32'h500, wdata:32'h0, size:2'd1, rdata:32'h0000_BEEF, lat:1, hold:0};
    drive_req(v);
    serve(w);
    chk("to_sticky_after_access", bus.timeout_err, 1'b1);

    // Reset pulsed in the middle of an access, then a stale mem_rec.
    bus.m1_rw_req = 1'b1; bus.m1_rw = 1'b1; bus.m1_address = 32'h600;
    bus.m1_write_data = 32'h6666_6666; bus.m1_size = 2'd2;
    tick();
    tick();
    chk("mid_reset_in_access", {bus.mem_rw_req, bus.busy}, 2'b11);
    reset = 1'b1;
    bus.m1_rw_req = 1'b0;
    tick();
    reset = 1'b0;
    check_reset_state("mid_reset");
    bus.mem_rec = 1'b1;
    tick();
    chk("post_reset_stale_rec", {bus.m0_rec, bus.m1_rec, bus.busy, bus.mem_rw_req}, 4'b0000);
    bus.mem_rec = 1'b0;
    v = '{m:1'b1, rw:1'b0, addr:32'h700, wdata:32'h0, size:2'd2, rdata:32'h7070_7070, lat:3, hold:1};
    drive_req(v);
    serve(w);
    chk("post_reset_wait", w, 1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
